// File: rtl/mem_sys_pkg.sv
// Shared memory-map constants, TX state encoding and baud divisor helper for mem_sys.
package mem_sys_pkg;

  localparam int IO_PAGE_BIT = 22;

  localparam logic [2:0] IO_LED       = 3'd0;
  localparam logic [2:0] IO_UART_DATA = 3'd1;
  localparam logic [2:0] IO_UART_STAT = 3'd2;
  localparam logic [2:0] IO_CYCLE     = 3'd3;

  localparam int STAT_FULL = 0;
  localparam int STAT_BUSY = 1;
  localparam int STAT_OVF  = 2;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  // Clocks per UART bit, truncated, never below one.
  function automatic int baud_div(input int clk_hz, input int baud);
    return ((clk_hz / baud) < 1) ? 1 : (clk_hz / baud);
  endfunction

endpackage

// File: rtl/mem_sys_uart_tx.sv
// Buffered 8N1 UART transmitter: circular TX FIFO feeding a start/data/stop serialiser.
module uart_tx
  import mem_sys_pkg::*;
#(
  parameter int CLK_HZ    = 12000000,
  parameter int BAUD      = 115200,
  parameter int TXQ_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] din,
  output logic       full,
  output logic       busy,
  output logic       overflow,
  input  logic       ovf_clr,
  output logic       txd
);

  localparam int DIV = baud_div(CLK_HZ, BAUD);
  localparam int DW  = $clog2(DIV + 1);
  localparam int PW  = $clog2(TXQ_DEPTH);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [PW:0]   DEPTH_C  = (PW+1)'(TXQ_DEPTH);

  logic [7:0]    fifo_r [TXQ_DEPTH];
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] wr_ptr_r;
  logic [PW:0]   count_r;
  logic          ovf_r;
  logic          full_s;
  logic          empty_s;
  logic          pop_s;
  logic          push_ok_s;
  logic          bit_end_s;
  tx_state_e     state_r;
  tx_state_e     state_next_s;
  logic [DW-1:0] div_r;
  logic [2:0]    bit_r;
  logic [7:0]    shift_r;
  logic          txd_s;
  logic          txd_r;

  assign full_s    = (count_r == DEPTH_C);
  assign empty_s   = (count_r == '0);
  assign push_ok_s = push && (!full_s || pop_s);
  assign bit_end_s = (div_r == '0);

  // FIFO byte storage
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      fifo_r[wr_ptr_r] <= din;
    end
  end

  // FIFO pointers and occupancy; a push into a full FIFO is accepted only alongside a pop
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (pop_s)     rd_ptr_r <= rd_ptr_r + PW'(1);
      case ({push_ok_s, pop_s})
        2'b10:   count_r <= count_r + (PW+1)'(1);
        2'b01:   count_r <= count_r - (PW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky overflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_r <= 1'b0;
    end else if (ovf_clr) begin
      ovf_r <= 1'b0;
    end else if (push && full_s && !pop_s) begin
      ovf_r <= 1'b1;
    end
  end

  // Serialiser state register
  always_ff @(posedge clk) begin
    if (rst) state_r <= TX_IDLE;
    else     state_r <= state_next_s;
  end

  // Serialiser next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      TX_IDLE:  if (!empty_s) state_next_s = TX_START; else state_next_s = TX_IDLE;
      TX_START: if (bit_end_s) state_next_s = TX_DATA; else state_next_s = TX_START;
      TX_DATA:  if (bit_end_s && (bit_r == 3'd7)) state_next_s = TX_STOP; else state_next_s = TX_DATA;
      TX_STOP:  if (bit_end_s) state_next_s = TX_IDLE; else state_next_s = TX_STOP;
      default:  state_next_s = TX_IDLE;
    endcase
  end

  // Serialiser outputs: FIFO pop request and line level
  always_comb begin
    pop_s = 1'b0;
    txd_s = 1'b1;
    case (state_r)
      TX_IDLE:  begin pop_s = !empty_s; txd_s = 1'b1; end
      TX_START: txd_s = 1'b0;
      TX_DATA:  txd_s = shift_r[0];
      TX_STOP:  txd_s = 1'b1;
      default:  begin pop_s = 1'b0; txd_s = 1'b1; end
    endcase
  end

  // Bit-time divisor, bit counter and shift register, reloaded at every bit boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      div_r   <= '0;
      bit_r   <= 3'd0;
      shift_r <= 8'd0;
    end else begin
      case (state_r)
        TX_IDLE: begin
          if (pop_s) begin
            shift_r <= fifo_r[rd_ptr_r];
            div_r   <= DIV_LAST;
            bit_r   <= 3'd0;
          end
        end
        TX_START: begin
          if (bit_end_s) begin
            div_r <= DIV_LAST;
            bit_r <= 3'd0;
          end else begin
            div_r <= div_r - DW'(1);
          end
        end
        TX_DATA: begin
          if (bit_end_s) begin
            div_r   <= DIV_LAST;
            bit_r   <= bit_r + 3'd1;
            shift_r <= {1'b0, shift_r[7:1]};
          end else begin
            div_r <= div_r - DW'(1);
          end
        end
        TX_STOP: begin
          if (!bit_end_s) div_r <= div_r - DW'(1);
        end
        default: div_r <= '0;
      endcase
    end
  end

  // Registered line driver, idle high
  always_ff @(posedge clk) begin
    if (rst) txd_r <= 1'b1;
    else     txd_r <= txd_s;
  end

  assign full     = full_s;
  assign busy     = (state_r != TX_IDLE) || !empty_s;
  assign overflow = ovf_r;
  assign txd      = txd_r;

endmodule

// File: rtl/mem_sys.sv
// Memory/IO subsystem: word RAM, LED register, UART TX and status, fixed 1-cycle reads.
// Build option MEM_CYCLE_CNT_EN adds a free-running cycle counter readable at IO offset 0x0C.
module mem_sys
  import mem_sys_pkg::*;
#(
  parameter int RAM_WORDS = 4096,
  parameter int CLK_HZ    = 12000000,
  parameter int BAUD      = 115200,
  parameter int TXQ_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wmask,
  input  logic        mem_rstrb,
  output logic [31:0] mem_rdata,
  output logic [7:0]  leds,
  output logic        txd
);

  localparam int AW = $clog2(RAM_WORDS);

  logic [31:0]   ram_r [RAM_WORDS];
  logic [AW-1:0] ram_idx_s;
  logic          io_sel_s;
  logic [2:0]    io_reg_s;
  logic          ram_we_s;
  logic          led_we_s;
  logic          tx_push_s;
  logic          ovf_clr_s;
  logic          tx_full_s;
  logic          tx_busy_s;
  logic          tx_ovf_s;
  logic [31:0]   io_rdata_s;
  logic [31:0]   cycle_val_s;
  logic [31:0]   rdata_r;
  logic [7:0]    leds_r;
  logic          unused_s;

  // Upper RAM address bits alias by design
  assign ram_idx_s = mem_addr[AW+1:2];
  assign io_sel_s  = mem_addr[IO_PAGE_BIT];
  assign io_reg_s  = mem_addr[4:2];
  assign ram_we_s  = !io_sel_s && (mem_wmask != 4'b0000);
  assign led_we_s  = io_sel_s && (io_reg_s == IO_LED) && mem_wmask[0];
  assign tx_push_s = io_sel_s && (io_reg_s == IO_UART_DATA) && mem_wmask[0];
  assign ovf_clr_s = io_sel_s && (io_reg_s == IO_UART_STAT) && (mem_wmask != 4'b0000);
  assign unused_s  = ^{mem_addr, mem_wdata};

  // Byte-lane RAM write
  always_ff @(posedge clk) begin
    if (ram_we_s) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_wmask[i]) ram_r[ram_idx_s][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

`ifdef MEM_CYCLE_CNT_EN
  logic [31:0] cycle_r;

  // Free-running cycle counter
  always_ff @(posedge clk) begin
    if (rst) cycle_r <= 32'd0;
    else     cycle_r <= cycle_r + 32'd1;
  end

  assign cycle_val_s = cycle_r;
`else
  assign cycle_val_s = 32'd0;
`endif

  // IO register read mux
  always_comb begin
    io_rdata_s = 32'd0;
    case (io_reg_s)
      IO_LED:       io_rdata_s = {24'd0, leds_r};
      IO_UART_STAT: begin
        io_rdata_s[STAT_FULL] = tx_full_s;
        io_rdata_s[STAT_BUSY] = tx_busy_s;
        io_rdata_s[STAT_OVF]  = tx_ovf_s;
      end
      IO_CYCLE:     io_rdata_s = cycle_val_s;
      default:      io_rdata_s = 32'd0;
    endcase
  end

  // Registered read port; holds until the next strobe, same-cycle writes read old data
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_r <= 32'd0;
    end else if (mem_rstrb) begin
      rdata_r <= io_sel_s ? io_rdata_s : ram_r[ram_idx_s];
    end
  end

  // LED register
  always_ff @(posedge clk) begin
    if (rst) begin
      leds_r <= 8'd0;
    end else if (led_we_s) begin
      leds_r <= mem_wdata[7:0];
    end
  end

  uart_tx #(
    .CLK_HZ    (CLK_HZ),
    .BAUD      (BAUD),
    .TXQ_DEPTH (TXQ_DEPTH)
  ) u_uart_tx (
    .clk      (clk),
    .rst      (rst),
    .push     (tx_push_s),
    .din      (mem_wdata[7:0]),
    .full     (tx_full_s),
    .busy     (tx_busy_s),
    .overflow (tx_ovf_s),
    .ovf_clr  (ovf_clr_s),
    .txd      (txd)
  );

  assign mem_rdata = rdata_r;
  assign leds      = leds_r;

endmodule
